// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with registered sync, data-enable,
// line/frame strobes and a frame counter, all advanced by a pixel clock enable.
module vga_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 400,
  parameter int   V_FP      = 12,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 35,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b1,
  parameter int   H_W       = 10,
  parameter int   V_W       = 9,
  parameter int   FRAME_W   = 8
) (
  input  logic               clk25,
  input  logic               reset_n,
  input  logic               ce,
  output logic [H_W-1:0]     horizontal,
  output logic [V_W-1:0]     vertical,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_DE_END   = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] H_SYNC_BEG = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_DE_END   = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] V_SYNC_BEG = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_W-1:0] h_nxt;
  logic [V_W-1:0] v_nxt;
  logic           h_wrap;
  logic           v_wrap;
  logic           h_sync_win;
  logic           v_sync_win;
  logic           de_nxt;

  // Region decode works on the next counter values so the registered sync/de
  // line up with the counters shown in the same cycle.
  always_comb begin
    h_wrap = (horizontal == H_LAST);
    v_wrap = (vertical == V_LAST);
    h_nxt  = h_wrap ? '0 : horizontal + 1'b1;
    v_nxt  = vertical;
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : vertical + 1'b1;
    end
    h_sync_win = (h_nxt >= H_SYNC_BEG) && (h_nxt < H_SYNC_END);
    v_sync_win = (v_nxt >= V_SYNC_BEG) && (v_nxt < V_SYNC_END);
    de_nxt     = (h_nxt < H_DE_END) && (v_nxt < V_DE_END);
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      horizontal  <= H_LAST;
      vertical    <= V_LAST;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      // Strobes are single-cycle: they drop on the next edge even with ce low.
      line_start  <= ce & h_wrap;
      frame_start <= ce & h_wrap & v_wrap;
      if (ce) begin
        horizontal <= h_nxt;
        vertical   <= v_nxt;
        hsync      <= h_sync_win ? HSYNC_POL : ~HSYNC_POL;
        vsync      <= v_sync_win ? VSYNC_POL : ~VSYNC_POL;
        de         <= de_nxt;
        if (h_wrap && v_wrap) begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised raster timing generator driving the display pipeline from the pixel clock domain.
- Produces pixel/line counters, hsync/vsync with programmable polarity, a data-enable, line/frame start strobes and a frame counter.
- Generalises the fixed 800×449 pixel counter: porches, sync widths and polarity are parameters, a clock-enable input is added, and sync and strobe generation are new.
- Defaults give 640×400 @ 70 Hz: 800 clocks × 449 lines.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks), ≥1
- V_ACTIVE, 400, visible lines per frame
- V_FP, 12, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 35, vertical back porch (lines), ≥1
- HSYNC_POL, 0, asserted level of hsync
- VSYNC_POL, 1, asserted level of vsync
- H_W, 10, horizontal counter width; H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP ≤ 2^H_W
- V_W, 9, vertical counter width; V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP ≤ 2^V_W
- FRAME_W, 8, frame counter width

Ports:
- clk25  input  1  pixel clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- ce  input  1  pixel advance enable; 1 = advance one pixel this edge
- horizontal  output  H_W  current pixel column, 0..H_TOTAL-1
- vertical  output  V_W  current line, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, polarity per HSYNC_POL
- vsync  output  1  vertical sync, polarity per VSYNC_POL
- de  output  1  data enable; 1 inside the active area
- line_start  output  1  one-clock strobe when horizontal becomes 0
- frame_start  output  1  one-clock strobe when (horizontal, vertical) becomes (0,0)
- frame_cnt  output  FRAME_W  completed frame count, modulo 2^FRAME_W

Behaviour:
- All outputs are registered. There is no combinational path from ce to any output.
- Reset (reset_n=0, asynchronous, takes effect immediately):
  - horizontal=H_TOTAL-1, vertical=V_TOTAL-1 (last back-porch pixel)
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL
  - de=0, line_start=0, frame_start=0, frame_cnt=0
- The first ce=1 edge after reset release yields (0,0) with frame_start=1.
- Advance on a clk25 edge with ce=1:
  - If horizontal==H_TOTAL-1: horizontal←0 and vertical advances (vertical==V_TOTAL-1 → 0, else +1).
  - Otherwise horizontal←horizontal+1; vertical holds.
- ce=0: horizontal, vertical, hsync, vsync, de and frame_cnt hold.
- Strobes:
  - line_start and frame_start are 1 only in the clock cycle immediately after an advancing edge that produced horizontal=0 (line_start) or (0,0) (frame_start).
  - They clear on the next clk25 edge regardless of ce.
  - frame_start always coincides with line_start.
- Region decode is aligned with the counters: hsync, vsync and de in any cycle correspond to the horizontal/vertical values shown in that same cycle (zero relative latency).
  - de=1 iff horizontal<H_ACTIVE and vertical<V_ACTIVE.
  - hsync=HSYNC_POL iff H_ACTIVE+H_FP ≤ horizontal < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL.
  - vsync=VSYNC_POL iff V_ACTIVE+V_FP ≤ vertical < V_ACTIVE+V_FP+V_SYNC, else ~VSYNC_POL. vsync changes only together with horizontal→0.
- frame_cnt increments on the same edge that produces frame_start. It wraps 2^FRAME_W-1 → 0, so the first frame after reset reads 1.
- Reset asserted mid-frame returns immediately to the reset state; no partial strobes are emitted.
- Counters never take values ≥ H_TOTAL or ≥ V_TOTAL.
- Arithmetic is unsigned at H_W/V_W width.

Test Plan:
- Reset, then ce=1 constant with defaults:
  - first edge → horizontal=0, vertical=0, frame_start=1, line_start=1, de=1, frame_cnt=1
  - horizontal reaches 799 then 0; vertical reaches 448 then 0
  - exactly 359,200 clocks between frame_start pulses
- Sync windows with defaults:
  - hsync=0 exactly for horizontal 656..751 (96 clocks), 1 elsewhere
  - vsync=1 exactly for vertical 412..413, 0 elsewhere
  - de=1 only for horizontal<640 and vertical<400
- ce toggling 1,0,0,1 at horizontal=799: counters and sync hold through ce=0; line_start is high for one clock only, not held during the ce=0 cycles.
- Assert reset_n=0 mid-line at (300,200) for 3 clocks:
  - outputs go to the reset state asynchronously, before the next edge
  - after release, the first ce edge gives (0,0) with frame_start=1 and frame_cnt=1
- Parameter override H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, HSYNC_POL=1, FRAME_W=2:
  - line of 8 clocks, frame of 6 lines
  - hsync=1 at horizontal 5..6
  - frame_cnt sequence 1,2,3,0,1 across 5 frames
